// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, FSM states and address field helpers for the 2-way instruction cache.
package icache_pkg;
   localparam int S_TAG    = 24;
   localparam int S_INDEX  = 3;
   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 256;

   typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, RELOAD} state_t;

   function automatic logic [S_TAG-1:0] addr_tag(input logic [31:0] a);
      return a[31:8];
   endfunction

   function automatic logic [S_INDEX-1:0] addr_index(input logic [31:0] a);
      return a[7:5];
   endfunction

   function automatic logic [2:0] addr_word(input logic [31:0] a);
      return a[4:2];
   endfunction
endpackage

// File: rtl/icache_if.sv
// icache_if: CPU fetch port and memory-arbiter line port of the instruction cache.
interface icache_if;
   import icache_pkg::*;
   logic              mem_read;
   logic [31:0]       mem_address;
   logic [31:0]       mem_rdata;
   logic              mem_resp;
   logic              pmem_read;
   logic [31:0]       pmem_address;
   logic [S_LINE-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      input  mem_read, mem_address, pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_read, pmem_address
   );
   modport slave (
      output mem_read, mem_address, pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_read, pmem_address
   );
endinterface

// File: rtl/icache_lru.sv
// icache_lru: one LRU bit per set; the stored bit names the way to evict next.
module icache_lru
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [S_INDEX-1:0] index,
   input  logic               we,
   input  logic               wdata,
   output logic               rdata
);
   logic [(1<<S_INDEX)-1:0] lru_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) lru_q <= '0;
      else if (we) lru_q[index] <= wdata;

   assign rdata = lru_q[index];
endmodule

// File: rtl/icache_control.sv
// icache_control: hit/miss FSM, victim choice and way strobes for the 2-way instruction cache.
module icache_control
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   icache_if.master          bus,
   output logic [31:0]       way_address,
   output logic              way_read,
   output logic [S_LINE-1:0] way_data_in,
   output logic              way_valid_in,
   output logic [1:0]        way_load_tag,
   output logic [1:0]        way_load_valid,
   output logic [31:0]       way_byte_en0,
   output logic [31:0]       way_byte_en1,
   input  logic [S_TAG-1:0]  way_tag_out0,
   input  logic [S_TAG-1:0]  way_tag_out1,
   input  logic              way_valid_out0,
   input  logic              way_valid_out1,
   input  logic [S_LINE-1:0] way_data_out0,
   input  logic [S_LINE-1:0] way_data_out1
);
   state_t            state, state_n;
   logic [31:0]       addr;
   logic [1:0]        vld;
   logic              hit0, hit1, hit, victim, lru_bit, lru_we, lru_wd;
   logic [S_LINE-1:0] line;

   icache_lru u_lru (
      .clk(clk), .rst(rst), .index(addr_index(addr)),
      .we(lru_we), .wdata(lru_wd), .rdata(lru_bit)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
         vld   <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.mem_read) addr <= bus.mem_address;
         if (state == LOOKUP) vld <= {way_valid_out1, way_valid_out0};
      end

   assign hit0             = way_valid_out0 && (way_tag_out0 == addr_tag(addr));
   assign hit1             = way_valid_out1 && (way_tag_out1 == addr_tag(addr));
   assign hit              = hit0 | hit1;
   assign line             = hit0 ? way_data_out0 : way_data_out1;
   // Empty ways are filled before any valid line is displaced.
   assign victim           = !vld[0] ? 1'b0 : !vld[1] ? 1'b1 : lru_bit;
   assign bus.mem_rdata    = line[{addr_word(addr), 5'b0} +: 32];
   assign bus.pmem_address = {addr[31:5], 5'b0};
   assign way_data_in      = bus.pmem_rdata;
   assign way_valid_in     = 1'b1;

   always_comb begin
      state_n        = state;
      way_address    = addr;
      way_read       = 1'b0;
      bus.mem_resp   = 1'b0;
      bus.pmem_read  = 1'b0;
      way_load_tag   = 2'b00;
      way_load_valid = 2'b00;
      way_byte_en0   = '0;
      way_byte_en1   = '0;
      lru_we         = 1'b0;
      lru_wd         = 1'b0;
      case (state)
         IDLE: begin
            way_address = bus.mem_address;
            way_read    = bus.mem_read && !rst;
            state_n     = bus.mem_read ? LOOKUP : IDLE;
         end
         LOOKUP: begin
            bus.mem_resp = hit;
            lru_we       = hit;
            lru_wd       = hit0;
            state_n      = hit ? IDLE : FETCH;
         end
         FETCH: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               way_load_tag   = victim ? 2'b10 : 2'b01;
               way_load_valid = victim ? 2'b10 : 2'b01;
               way_byte_en0   = {32{!victim}};
               way_byte_en1   = {32{victim}};
               lru_we         = 1'b1;
               lru_wd         = ~victim;
               state_n        = RELOAD;
            end
         end
         RELOAD: begin
            way_read = 1'b1;
            state_n  = LOOKUP;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_icache_control.sv
// tb_icache_control: directed checks of icache_control against behavioural ways and a fixed-latency arbiter.
module tb_icache_control;
   import icache_pkg::*;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       way_address;
   logic              way_read;
   logic [S_LINE-1:0] way_data_in;
   logic              way_valid_in;
   logic [1:0]        way_load_tag, way_load_valid;
   logic [31:0]       way_byte_en0, way_byte_en1;
   logic [S_TAG-1:0]  way_tag_out0, way_tag_out1;
   logic              way_valid_out0, way_valid_out1;
   logic [S_LINE-1:0] way_data_out0, way_data_out1;

   logic [S_TAG-1:0]  tag_m [2][8];
   logic              val_m [2][8];
   logic [S_LINE-1:0] dat_m [2][8];
   logic [S_TAG-1:0]  tq [2];
   logic              vq [2];
   logic [S_LINE-1:0] dq [2];

   int          n_chk = 0, n_fail = 0, pm_reqs = 0, p0;
   logic [31:0] last_paddr = '0;

   always #5 clk = ~clk;

   icache_if bus();

   icache_control dut (
      .clk(clk), .rst(rst), .bus(bus),
      .way_address(way_address), .way_read(way_read), .way_data_in(way_data_in),
      .way_valid_in(way_valid_in), .way_load_tag(way_load_tag), .way_load_valid(way_load_valid),
      .way_byte_en0(way_byte_en0), .way_byte_en1(way_byte_en1),
      .way_tag_out0(way_tag_out0), .way_tag_out1(way_tag_out1),
      .way_valid_out0(way_valid_out0), .way_valid_out1(way_valid_out1),
      .way_data_out0(way_data_out0), .way_data_out1(way_data_out1)
   );

   // Behavioural cache ways: registered read, synchronous fill.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) val_m[w][s] <= 1'b0;
            vq[w] <= 1'b0;
         end
      end else begin
         for (int w = 0; w < 2; w++) begin
            if (way_load_tag[w]) tag_m[w][way_address[7:5]] <= way_address[31:8];
            if (way_load_valid[w]) val_m[w][way_address[7:5]] <= way_valid_in;
            if (w == 0 ? &way_byte_en0 : &way_byte_en1) dat_m[w][way_address[7:5]] <= way_data_in;
            if (way_read) begin
               tq[w] <= tag_m[w][way_address[7:5]];
               vq[w] <= val_m[w][way_address[7:5]];
               dq[w] <= dat_m[w][way_address[7:5]];
            end
         end
      end
   end

   assign way_tag_out0   = tq[0];
   assign way_tag_out1   = tq[1];
   assign way_valid_out0 = vq[0];
   assign way_valid_out1 = vq[1];
   assign way_data_out0  = dq[0];
   assign way_data_out1  = dq[1];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      if (a[31:5] == 27'h2 && a[4:2] == 3'd1) return 32'hDEADBEEF;
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [S_LINE-1:0] line_of(input logic [31:0] a);
      logic [S_LINE-1:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = word_of({a[31:5], i[2:0], 2'b00});
      return l;
   endfunction

   // Arbiter: answers each line request LAT cycles after it first appears.
   initial begin
      int  cnt;
      logic prev;
      cnt = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.pmem_read && !prev) begin
            pm_reqs++;
            last_paddr = bus.pmem_address;
         end
         prev = bus.pmem_read;
         if (rst || bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            cnt = 0;
         end else if (bus.pmem_read) begin
            cnt++;
            if (cnt == LAT) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = line_of(bus.pmem_address);
               cnt = 0;
            end
         end else cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic req(input string tag, input logic [31:0] a, input int lat);
      int n;
      bus.mem_read    = 1'b1;
      bus.mem_address = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_resp && n < 40);
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " rdata"}, 64'(bus.mem_rdata), 64'(word_of(a)));
      bus.mem_read = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.mem_read = 1'b1;
      bus.mem_address = 32'h44;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = '0;
      repeat (2) @(negedge clk);
      check("reset way_read", 64'(way_read), 64'd0);
      check("reset mem_resp", 64'(bus.mem_resp), 64'd0);
      check("reset pmem_read", 64'(bus.pmem_read), 64'd0);
      bus.mem_read = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      p0 = pm_reqs;
      req("cold", 32'h44, 3 + LAT);
      check("cold paddr", 64'(last_paddr), 64'h40);
      check("cold one fetch", 64'(pm_reqs - p0), 64'd1);
      check("cold lru2", 64'(dut.u_lru.lru_q[2]), 64'd1);
      check("cold way0 valid", 64'(val_m[0][2]), 64'd1);
      check("cold way0 tag", 64'(tag_m[0][2]), 64'h0);

      @(negedge clk);
      bus.mem_read = 1'b1;
      bus.mem_address = 32'h80;
      n = 0;
      while (!bus.pmem_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("fetch reached", 64'(bus.pmem_read), 64'd1);
      rst = 1'b1;
      bus.mem_read = 1'b0;
      #1;
      check("rst pmem_read", 64'(bus.pmem_read), 64'd0);
      check("rst mem_resp", 64'(bus.mem_resp), 64'd0);
      check("rst state", 64'(dut.state), 64'(IDLE));
      check("rst lru", 64'(dut.u_lru.lru_q), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      req("cold again", 32'h44, 3 + LAT);
      check("cold again lru2", 64'(dut.u_lru.lru_q[2]), 64'd1);
      @(negedge clk);
      p0 = pm_reqs;
      req("hit", 32'h44, 1);
      check("hit no fetch", 64'(pm_reqs - p0), 64'd0);

      @(negedge clk);
      req("fill way1", 32'h1040, 3 + LAT);
      check("way1 valid", 64'(val_m[1][2]), 64'd1);
      check("way1 tag", 64'(tag_m[1][2]), 64'h10);
      check("fill way1 lru2", 64'(dut.u_lru.lru_q[2]), 64'd0);

      @(negedge clk);
      req("evict way0", 32'h2040, 3 + LAT);
      check("evict way0 tag", 64'(tag_m[0][2]), 64'h20);
      check("evict way1 kept", 64'(tag_m[1][2]), 64'h10);
      check("evict lru2", 64'(dut.u_lru.lru_q[2]), 64'd1);

      @(negedge clk);
      p0 = pm_reqs;
      req("way1 still hits", 32'h1040, 1);
      check("way1 hit no fetch", 64'(pm_reqs - p0), 64'd0);
      @(negedge clk);
      p0 = pm_reqs;
      req("remiss", 32'h44, 3 + LAT);
      check("remiss fetched", 64'(pm_reqs - p0), 64'd1);
      check("remiss replaced way0", 64'(tag_m[0][2]), 64'h0);

      for (int s = 0; s < 8; s++) begin
         if (s == 2) continue;
         @(negedge clk);
         req("fill set", 32'(s) << 5, 3 + LAT);
      end

      @(negedge clk);
      p0 = pm_reqs;
      for (int i = 0; i < 16; i++)
         req("b2b", (32'(i % 8) << 5) | (32'(i % 8) << 2), i == 0 ? 1 : 2);
      check("b2b no fetch", 64'(pm_reqs - p0), 64'd0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/icache_control.md
Name: icache_control

Overview:
- Controller and datapath glue for the 2-way instruction cache, directly downstream of the two cache_way instances. It consumes each way's tag, valid and data outputs and drives their read and load strobes.
- Serves 32-bit CPU fetch reads and handles misses by fetching a 256-bit line from the memory arbiter.
- Owns the per-set LRU state and the victim choice.

Parameters:
- S_TAG, 24, tag bits (address[31:8])
- S_INDEX, 3, set index bits (address[7:5]); 8 sets
- S_OFFSET, 5, byte offset bits within a 32-byte line
- S_LINE, 256, line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  CPU fetch request; held with mem_address stable until mem_resp
- mem_address  in  32  CPU fetch byte address
- mem_rdata  out  32  fetched instruction word
- mem_resp  out  1  one-cycle response pulse
- pmem_read  out  1  line fetch request to arbiter
- pmem_address  out  32  line-aligned fetch address {tag,index,5'b0}
- pmem_rdata  in  256  fetched line
- pmem_resp  in  1  arbiter response, one cycle
- way_address  out  32  address driven to both ways
- way_read  out  1  read strobe to both ways (read_all)
- way_data_in  out  256  fill data to both ways (= pmem_rdata)
- way_valid_in  out  1  constant 1
- way_load_tag  out  2  per-way tag load
- way_load_valid  out  2  per-way valid load
- way_byte_en0, way_byte_en1  out  32 each  per-way write enables
- way_tag_out0, way_tag_out1  in  24 each  way tags
- way_valid_out0, way_valid_out1  in  1 each  way valids
- way_data_out0, way_data_out1  in  256 each  way lines

Behaviour:
- Way arrays have a registered read. Address and way_read sampled at edge N give outputs valid throughout cycle N+1.
- Reset (async, immediate):
  - state=IDLE, LRU bits all 0, captured address 0.
  - mem_resp, pmem_read, way_load_*, way_byte_en* all 0; way_read 0.
  - Reset during FETCH drops pmem_read immediately. The arbiter tolerates an abandoned request.
- IDLE:
  - way_address=mem_address (combinational); way_read=mem_read.
  - If mem_read: capture mem_address, go LOOKUP.
- LOOKUP:
  - way_address=captured address.
  - hit_w = way_valid_out_w && (way_tag_out_w == captured tag). If both ways hit, way0 has priority.
  - Hit:
    - mem_resp=1 combinationally this cycle.
    - mem_rdata = hit line[32*offset[4:2] +: 32]; offset[1:0] ignored.
    - lru[index] <= ~hit_way; go IDLE.
    - Hit latency is 1 cycle after the request is first seen in IDLE.
  - Miss: go FETCH; mem_resp=0.
- FETCH:
  - pmem_read=1; pmem_address={captured[31:5],5'b0}, stable until pmem_resp.
  - Victim: way0 if !valid0, else way1 if !valid1, else lru[index]. Valids are sampled in LOOKUP and registered.
  - On pmem_resp in this cycle: way_byte_en_victim=32'hFFFFFFFF, way_load_tag[victim]=1, way_load_valid[victim]=1; lru[index] <= ~victim; go RELOAD.
  - pmem_read drops in the cycle after pmem_resp.
- RELOAD:
  - way_read=1 with captured address; go LOOKUP. This always hits.
  - Miss latency = 3 cycles + arbiter latency.
- No write path: the instruction cache is read-only, and no dirty state or writeback exists.
- mem_read deasserted outside IDLE: the FSM completes the current sequence anyway. mem_resp is still pulsed and the CPU ignores it.
- Back-to-back hits: one request completes every 2 cycles (IDLE, LOOKUP). There is no hit pipelining.

Decomposition:
- icache_pkg:
  - state enum {IDLE, LOOKUP, FETCH, RELOAD}
  - width constants S_TAG/S_INDEX/S_OFFSET/S_LINE
  - address field extract functions (tag, index, word)
- Sub-module icache_lru: 8x1 flop array with async-reset, combinational read at index, write-enable plus write data.

Test Plan:
- Reset asserted mid-FETCH (pmem_read=1) -> pmem_read and mem_resp go 0 the same cycle; state IDLE; all LRU bits 0.
- Cold read 0x0000_0044 -> pmem_read with pmem_address=0x0000_0040. Arbiter returns a line with word1=0xDEADBEEF -> way0 filled (tag 0x000000, set 2); mem_resp with mem_rdata=0xDEADBEEF; lru[2]=1.
- Repeat read 0x0000_0044 -> mem_resp 1 cycle after the request; no pmem_read; mem_rdata=0xDEADBEEF.
- Read 0x0000_1040 (set 2, new tag 0x000010) -> fills way1 (invalid way first); lru[2]=0.
- Then read 0x0000_2040 -> evicts way0 (LRU); a following read of 0x0000_0044 misses again, while 0x0000_1040 still hits.
- 16 alternating hits across sets 0-7 -> every response arrives exactly 2 cycles apart; pmem_read never asserted.
